door_lock_ctrl: RTL and testbench

- Keypad-driven digital door lock controller holding a 4-digit BCD password.
- Accepts digit keys 0-9, star (confirm) and hash (clear/change), a door close sensor and an inside open button.
- Drives the unlock solenoid, an alarm output, a 4-nibble keypad display and a 10-bit scrambled keypad indicator.
- Top of the lock subsystem; all inputs are already synchronous to clk.

---
 rtl/door_lock_pkg.sv | 36 +++
 rtl/door_lock_ctrl_key_edge_detect.sv | 29 ++
 rtl/door_lock_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_door_lock_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_lock_pkg.sv
// Shared types, constants and helpers for the keypad door lock.
// Optional feature macro used by the lock: RANDOM_KEYPAD_EN (scrambled keypad LFSR).
package door_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        SET      = 2'd2,
        ALERT    = 2'd3
    } lock_state_e;

    localparam logic [3:0]  BLANK_NIBBLE  = 4'hF;
    localparam logic [15:0] BLANK_DISPLAY = {4{BLANK_NIBBLE}};
    localparam logic [15:0] ALERT_DISPLAY = 16'hEEEE;
    localparam int          DIGIT_CNT_W   = 3;
    localparam int          TIMER_W       = 16;

    // Fibonacci LFSR, taps 10 and 7; a nonzero state never maps to zero.
    function automatic logic [9:0] lfsr_step(input logic [9:0] cur);
        return {cur[8:0], cur[9] ^ cur[6]};
    endfunction

    function automatic logic [3:0] onehot_to_digit(input logic [9:0] keys);
        logic [3:0] val;
        val = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                val = 4'(i);
            end else begin
                val = val;
            end
        end
        return val;
    endfunction

endpackage

// File: rtl/door_lock_ctrl_key_edge_detect.sv
// Rising-edge detector for a vector of synchronous key inputs; a held key pulses once.
module key_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] keys,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    // Previous-sample register.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Edge pulse and next previous-sample value.
    always_comb begin
        prev_d = keys;
        rise   = keys & ~prev_q;
    end

endmodule

// File: rtl/door_lock_ctrl.sv
// Keypad door lock: 4-digit BCD password, alert lockout, auto relock, password change.
// Define RANDOM_KEYPAD_EN to build the scrambled keypad LFSR on random_button.
module door_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter logic [15:0] DEFAULT_PW       = 16'h0000,
    parameter int          MAX_FAIL         = 3,
    parameter int          LOCKOUT_CYCLES   = 20,
    parameter int          AUTO_LOCK_CYCLES = 40,
    parameter logic [9:0]  LFSR_SEED        = 10'h2A5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  button,
    input  logic        star,
    input  logic        hash,
    input  logic        open_button,
    input  logic        close_sensor,
    output logic [15:0] display,
    output logic [9:0]  random_button,
    output logic        alert,
    output logic        unlock
);

    localparam int                 FAIL_W     = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0]  MAX_FAIL_V = FAIL_W'(MAX_FAIL);
    localparam logic [TIMER_W-1:0] LOCK_LIM   = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] AUTO_LIM   = TIMER_W'(AUTO_LOCK_CYCLES);

    logic [9:0]             dig_e_s;
    logic [3:0]             ctl_e_s;
    logic                   star_e_s, hash_e_s, open_e_s, close_e_s;
    logic                   digit_ok_s, digit_take_s, leave_s;
    logic [3:0]             digit_val_s;
    logic [15:0]            buf_app_s;
    logic [FAIL_W-1:0]      fail_inc_s;
    logic [TIMER_W-1:0]     timer_inc_s;

    lock_state_e            state_q, state_d;
    logic [15:0]            pw_q, pw_d, buf_q, buf_d, display_q, display_d;
    logic [DIGIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [FAIL_W-1:0]      fail_q, fail_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   unlock_q, unlock_d, alert_q, alert_d;

    key_edge_detect #(.W(10)) u_digit_edge (
        .clk(clk), .reset(reset), .keys(button), .rise(dig_e_s)
    );

    key_edge_detect #(.W(4)) u_ctrl_edge (
        .clk(clk), .reset(reset),
        .keys({close_sensor, open_button, hash, star}), .rise(ctl_e_s)
    );

    // Decode control edges and the single-digit key value.
    always_comb begin
        star_e_s    = ctl_e_s[0];
        hash_e_s    = ctl_e_s[1];
        open_e_s    = ctl_e_s[2];
        close_e_s   = ctl_e_s[3];
        digit_ok_s  = $onehot(dig_e_s);
        digit_val_s = onehot_to_digit(dig_e_s);
    end

    // Entry buffer with the new digit placed after those already entered.
    always_comb begin
        case (cnt_q)
            3'd0:    buf_app_s = {digit_val_s, buf_q[11:0]};
            3'd1:    buf_app_s = {buf_q[15:12], digit_val_s, buf_q[7:0]};
            3'd2:    buf_app_s = {buf_q[15:8], digit_val_s, buf_q[3:0]};
            3'd3:    buf_app_s = {buf_q[15:4], digit_val_s};
            default: buf_app_s = buf_q;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOCKED;
            pw_q    <= DEFAULT_PW;
            buf_q   <= BLANK_DISPLAY;
            cnt_q   <= 3'd0;
            fail_q  <= FAIL_W'(0);
            timer_q <= TIMER_W'(0);
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic; close beats open beats star/hash beats digits.
    always_comb begin
        state_d      = state_q;
        pw_d         = pw_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        fail_d       = fail_q;
        timer_d      = timer_q;
        digit_take_s = 1'b0;
        fail_inc_s   = fail_q + FAIL_W'(1);
        timer_inc_s  = timer_q + TIMER_W'(1);
        case (state_q)
            LOCKED: begin
                if (open_e_s) begin
                    state_d = UNLOCKED;
                end else if (star_e_s) begin
                    if (cnt_q == 3'd0) begin
                        state_d = LOCKED;
                    end else if ((cnt_q == 3'd4) && (buf_q == pw_q)) begin
                        state_d = UNLOCKED;
                        fail_d  = FAIL_W'(0);
                    end else begin
                        fail_d  = fail_inc_s;
                        buf_d   = BLANK_DISPLAY;
                        cnt_d   = 3'd0;
                        state_d = (fail_inc_s >= MAX_FAIL_V) ? ALERT : LOCKED;
                    end
                end else if (hash_e_s) begin
                    buf_d = BLANK_DISPLAY;
                    cnt_d = 3'd0;
                end else begin
                    digit_take_s = digit_ok_s && (cnt_q < 3'd4);
                end
            end
            UNLOCKED: begin
                if (close_e_s) begin
                    state_d = LOCKED;
                end else if (open_e_s) begin
                    timer_d = TIMER_W'(0);
                end else if (star_e_s || hash_e_s) begin
                    state_d = SET;
                end else if (timer_inc_s >= AUTO_LIM) begin
                    state_d = LOCKED;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            SET: begin
                if (close_e_s) begin
                    state_d = LOCKED;
                end else if (star_e_s || hash_e_s) begin
                    pw_d    = (cnt_q == 3'd4) ? buf_q : pw_q;
                    state_d = UNLOCKED;
                end else begin
                    digit_take_s = digit_ok_s && (cnt_q < 3'd4);
                end
            end
            ALERT: begin
                if (open_e_s) begin
                    state_d = UNLOCKED;
                    fail_d  = FAIL_W'(0);
                end else if (timer_inc_s >= LOCK_LIM) begin
                    state_d = LOCKED;
                    fail_d  = FAIL_W'(0);
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
        buf_d   = digit_take_s ? buf_app_s : buf_d;
        cnt_d   = digit_take_s ? (cnt_q + 3'd1) : cnt_d;
        leave_s = (state_d != state_q);
        buf_d   = leave_s ? BLANK_DISPLAY : buf_d;
        cnt_d   = leave_s ? 3'd0 : cnt_d;
        timer_d = leave_s ? TIMER_W'(0) : timer_d;
    end

    // Output decode from the next state so registered outputs track the state.
    always_comb begin
        case (state_d)
            LOCKED:   display_d = buf_d;
            SET:      display_d = buf_d;
            UNLOCKED: display_d = BLANK_DISPLAY;
            ALERT:    display_d = ALERT_DISPLAY;
            default:  display_d = BLANK_DISPLAY;
        endcase
        unlock_d = (state_d == UNLOCKED) || (state_d == SET);
        alert_d  = (state_d == ALERT);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            display_q <= BLANK_DISPLAY;
            unlock_q  <= 1'b0;
            alert_q   <= 1'b0;
        end else begin
            display_q <= display_d;
            unlock_q  <= unlock_d;
            alert_q   <= alert_d;
        end
    end

    assign display = display_q;
    assign unlock  = unlock_q;
    assign alert   = alert_q;

`ifdef RANDOM_KEYPAD_EN
    logic [9:0] lfsr_q, lfsr_d;

    // Scramble LFSR steps once per digit accepted into the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Next LFSR value.
    always_comb begin
        lfsr_d = digit_take_s ? lfsr_step(lfsr_q) : lfsr_q;
    end

    assign random_button = lfsr_q;
`else
    // Seed is only meaningful with the scrambler built; the output stays zero.
    assign random_button = LFSR_SEED & 10'h000;
`endif

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Self-checking bench for door_lock_ctrl: directed scenarios plus random key traffic
// compared cycle by cycle against a queue-based behavioural model of the lock.
module tb_door_lock_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  button;
    logic        star, hash, open_button, close_sensor;
    logic [15:0] display;
    logic [9:0]  random_button;
    logic        alert, unlock;

    always #5 clk = ~clk;

    door_lock_ctrl dut (
        .clk(clk), .reset(reset), .button(button), .star(star), .hash(hash),
        .open_button(open_button), .close_sensor(close_sensor),
        .display(display), .random_button(random_button),
        .alert(alert), .unlock(unlock)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 locked, 1 unlocked, 2 set, 3 alert
    int          m_state;
    int          m_q[$];
    logic [15:0] m_pw;
    int          m_fail;
    int          m_idle;
    logic [9:0]  m_lfsr;
    logic [13:0] prev_in;

    function automatic logic [15:0] q_value();
        logic [15:0] v;
        v = 16'hFFFF;
        for (int i = 0; i < m_q.size(); i++) v[15-4*i -: 4] = 4'(m_q[i]);
        return v;
    endfunction

    function automatic logic [15:0] exp_display();
        if (m_state == 1) return 16'hFFFF;
        if (m_state == 3) return 16'hEEEE;
        return q_value();
    endfunction

    function automatic logic [9:0] exp_rb();
`ifdef RANDOM_KEYPAD_EN
        return m_lfsr;
`else
        return 10'h000;
`endif
    endfunction

    function automatic logic [11:0] exp_flags();
        return {(m_state == 3), (m_state == 1 || m_state == 2), exp_rb()};
    endfunction

    task automatic add_digit(input int d);
        int fb;
        if (m_q.size() < 4) begin
            m_q.push_back(d);
            fb = ((int'(m_lfsr) >> 9) ^ (int'(m_lfsr) >> 6)) & 1;
            m_lfsr = 10'(((int'(m_lfsr) << 1) | fb) & 1023);
        end
    endtask

    // ev: [9:0] digit edges, 10 star, 11 hash, 12 open, 13 close
    task automatic m_step(input logic [13:0] ev);
        int old = m_state;
        int dv = 0;
        bit one = ($countones(ev[9:0]) == 1);
        bit conf = ev[10] | ev[11];
        for (int i = 0; i < 10; i++) if (ev[i]) dv = i;
        case (m_state)
            0: begin
                if (ev[12]) m_state = 1;
                else if (ev[10]) begin
                    if (m_q.size() == 4 && q_value() == m_pw) begin
                        m_state = 1; m_fail = 0;
                    end else if (m_q.size() != 0) begin
                        m_fail++; m_q.delete();
                        if (m_fail >= 3) m_state = 3;
                    end
                end else if (ev[11]) m_q.delete();
                else if (one) add_digit(dv);
            end
            1: begin
                if (ev[13]) m_state = 0;
                else if (ev[12]) m_idle = 0;
                else if (conf) m_state = 2;
                else begin
                    m_idle++;
                    if (m_idle >= 40) m_state = 0;
                end
            end
            2: begin
                if (ev[13]) m_state = 0;
                else if (conf) begin
                    if (m_q.size() == 4) m_pw = q_value();
                    m_state = 1;
                end else if (one) add_digit(dv);
            end
            default: begin
                if (ev[12]) begin m_state = 1; m_fail = 0; end
                else begin
                    m_idle++;
                    if (m_idle >= 20) begin m_state = 0; m_fail = 0; end
                end
            end
        endcase
        if (m_state != old) begin m_q.delete(); m_idle = 0; end
    endtask

    task automatic tick(input logic [13:0] v);
        logic [13:0] ev;
        button = v[9:0]; star = v[10]; hash = v[11];
        open_button = v[12]; close_sensor = v[13];
        ev = v & ~prev_in;
        prev_in = v;
        @(posedge clk);
        m_step(ev);
        #1;
    endtask

    task automatic press(input int k, input int hold);
        logic [13:0] v;
        v = 14'd1 << k;
        repeat (hold) tick(v);
        tick(14'd0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) press(int'(c[15-4*i -: 4]), 1);
    endtask

    task automatic test_reset();
        reset = 1'b1; button = 10'd0; star = 1'b0; hash = 1'b0;
        open_button = 1'b0; close_sensor = 1'b0; prev_in = 14'd0;
        repeat (3) @(posedge clk);
        #1;
        m_state = 0; m_q.delete(); m_pw = 16'h0000; m_fail = 0; m_idle = 0;
        m_lfsr = 10'h2A5;
        n_checks++;
        if (display !== 16'hFFFF) begin
            n_fail++; $display("FAIL reset_display: got %h expected %h", display, 16'hFFFF);
        end
        n_checks++;
        if ({alert, unlock, random_button} !== exp_flags()) begin
            n_fail++; $display("FAIL reset_flags: got %h expected %h", {alert, unlock, random_button}, exp_flags());
        end
        reset = 1'b0;
    endtask

    task automatic test_default_unlock();
        enter_code(16'h0000);
        n_checks++;
        if (display !== 16'h0000) begin
            n_fail++; $display("FAIL default_display: got %h expected %h", display, 16'h0000);
        end
        tick(14'd1 << 10);
        n_checks++;
        if (unlock !== 1'b1) begin
            n_fail++; $display("FAIL default_unlock: got %b expected 1", unlock);
        end
        tick(14'd0);
    endtask

    task automatic test_change_pw();
        press(10, 1);
        enter_code(16'h9876);
        n_checks++;
        if (display !== 16'h9876) begin
            n_fail++; $display("FAIL set_display: got %h expected %h", display, 16'h9876);
        end
        press(10, 1);
        press(13, 1);
        n_checks++;
        if (unlock !== 1'b0) begin
            n_fail++; $display("FAIL close_lock: got %b expected 0", unlock);
        end
        enter_code(16'h0000);
        press(10, 1);
        n_checks++;
        if (unlock !== 1'b0) begin
            n_fail++; $display("FAIL old_pw_rejected: got %b expected 0", unlock);
        end
        enter_code(16'h9876);
        press(10, 1);
        n_checks++;
        if (unlock !== 1'b1) begin
            n_fail++; $display("FAIL new_pw_unlock: got %b expected 1", unlock);
        end
        press(13, 1);
    endtask

    task automatic test_alert();
        for (int n = 0; n < 3; n++) begin
            enter_code(16'h1111);
            tick(14'd1 << 10);
        end
        n_checks++;
        if ({alert, unlock, display} !== {1'b1, 1'b0, 16'hEEEE}) begin
            n_fail++; $display("FAIL alert_enter: got %b %b %h expected 1 0 eeee", alert, unlock, display);
        end
        repeat (19) tick(14'd0);
        n_checks++;
        if (alert !== 1'b1) begin
            n_fail++; $display("FAIL alert_hold: got %b expected 1", alert);
        end
        tick(14'd0);
        n_checks++;
        if ({alert, unlock, display} !== {1'b0, 1'b0, 16'hFFFF}) begin
            n_fail++; $display("FAIL alert_expire: got %b %b %h expected 0 0 ffff", alert, unlock, display);
        end
        enter_code(16'h9876);
        press(10, 1);
        n_checks++;
        if (unlock !== 1'b1) begin
            n_fail++; $display("FAIL after_alert_unlock: got %b expected 1", unlock);
        end
    endtask

    task automatic test_set_short();
        press(11, 1);
        press(2, 1);
        press(3, 1);
        press(11, 1);
        press(13, 1);
        enter_code(16'h9876);
        press(10, 1);
        n_checks++;
        if (unlock !== 1'b1) begin
            n_fail++; $display("FAIL short_set_keeps_pw: got %b expected 1", unlock);
        end
        press(13, 1);
    endtask

    task automatic test_auto_lock();
        tick(14'd1 << 12);
        n_checks++;
        if (unlock !== 1'b1) begin
            n_fail++; $display("FAIL open_button_unlock: got %b expected 1", unlock);
        end
        repeat (39) tick(14'd0);
        n_checks++;
        if (unlock !== 1'b1) begin
            n_fail++; $display("FAIL auto_lock_early: got %b expected 1", unlock);
        end
        tick(14'd0);
        n_checks++;
        if (unlock !== 1'b0) begin
            n_fail++; $display("FAIL auto_lock: got %b expected 0", unlock);
        end
    endtask

    task automatic test_key_hold();
        press(1, 10);
        n_checks++;
        if (display !== 16'h1FFF) begin
            n_fail++; $display("FAIL held_key: got %h expected %h", display, 16'h1FFF);
        end
        tick(14'h000C);
        tick(14'd0);
        n_checks++;
        if (display !== 16'h1FFF) begin
            n_fail++; $display("FAIL multi_key: got %h expected %h", display, 16'h1FFF);
        end
        press(2, 1); press(3, 1); press(4, 1); press(5, 2);
        n_checks++;
        if (display !== 16'h1234) begin
            n_fail++; $display("FAIL fifth_digit: got %h expected %h", display, 16'h1234);
        end
        press(11, 1);
        n_checks++;
        if ({display, random_button} !== {16'hFFFF, exp_rb()}) begin
            n_fail++; $display("FAIL hash_clear: got %h %h expected ffff %h", display, random_button, exp_rb());
        end
    endtask

    task automatic test_random();
        logic [13:0] seq[$];
        logic [13:0] v;
        logic [15:0] pw;
        for (int it = 0; it < 400; it++) begin
            int k = int'($urandom_range(0, 15));
            seq.delete();
            if (k == 14) begin
                pw = m_pw;
                for (int i = 0; i < 4; i++) begin
                    seq.push_back(14'd1 << pw[15-4*i -: 4]);
                    seq.push_back(14'd0);
                end
            end else if (k == 15) begin
                repeat ($urandom_range(1, 45)) seq.push_back(14'd0);
            end else begin
                v = 14'd1 << k;
                if (k < 10 && $urandom_range(0, 7) == 0) v[$urandom_range(0, 9)] = 1'b1;
                repeat ($urandom_range(1, 3)) seq.push_back(v);
                repeat ($urandom_range(0, 2)) seq.push_back(14'd0);
            end
            foreach (seq[i]) begin
                tick(seq[i]);
                n_checks++;
                if (display !== exp_display()) begin
                    n_fail++; $display("FAIL rand_display it=%0d: got %h expected %h", it, display, exp_display());
                end
                n_checks++;
                if ({alert, unlock, random_button} !== exp_flags()) begin
                    n_fail++; $display("FAIL rand_flags it=%0d: got %h expected %h", it, {alert, unlock, random_button}, exp_flags());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_unlock();
        test_change_pw();
        test_alert();
        test_set_short();
        test_auto_lock();
        test_key_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
